// File: rtl/dot_arbiter.sv
// Round-robin arbiter sharing one 3-stage fixed-point 3-element dot-product pipe
// between NUM_REQ requesters; results are tagged with the requester id and queued in a credit-protected FIFO.
module dot_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 16,
  parameter int A_FRAC_BITS = 14,
  parameter int B_WIDTH     = 16,
  parameter int B_FRAC_BITS = 14,
  parameter int P_FRAC_BITS = 14,
  parameter int FIFO_DEPTH  = 8,
  localparam int EXTRA      = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS,
  localparam int D_WIDTH    = A_WIDTH + B_WIDTH - EXTRA + 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [NUM_REQ-1:0]                     req_valid_in,
  output logic [NUM_REQ-1:0]                     req_ready_out,
  input  logic [NUM_REQ-1:0][2:0][A_WIDTH-1:0]   req_a_in,
  input  logic [NUM_REQ-1:0][2:0][B_WIDTH-1:0]   req_b_in,
  output logic                                   res_valid_out,
  input  logic                                   res_ready_in,
  output logic [D_WIDTH-1:0]                     res_data_out,
  output logic [ID_W-1:0]                        res_id_out,
  output logic                                   busy_out
);

  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int SW    = PW + 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [D_WIDTH-1:0] data;
  } res_t;

  // ---------------------------------------------------------------------------
  // Arbitration and credits
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic [CNT_W-1:0] credits_used;
  logic [CNT_W-1:0] credits_next;
  logic             can_issue;
  logic             issue;
  logic             pop;
  logic             busy_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch; combinational logic uses
  // blocking (=) assignments, sequential state uses non-blocking (<=).
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid_in[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign can_issue = (credits_used < CNT_W'(FIFO_DEPTH));
  assign issue     = rst_in && can_issue && grant_found;

  always_comb begin
    req_ready_out = '0;
    if (issue) req_ready_out[grant_id] = 1'b1;
  end

  // A credit is held from issue until the result leaves the FIFO, so the
  // pipe plus FIFO can never hold more than FIFO_DEPTH results.
  assign credits_next = credits_used + CNT_W'(issue) - CNT_W'(pop);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rr_ptr       <= '0;
      credits_used <= '0;
      busy_q       <= 1'b0;
    end else begin
      if (issue) rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      credits_used <= credits_next;
      busy_q       <= (credits_next != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: S1 operands, S2 products, S3 sum + shift
  // ---------------------------------------------------------------------------
  logic                         s1_valid, s2_valid, s3_valid;
  logic [ID_W-1:0]              s1_id, s2_id, s3_id;
  logic [2:0][A_WIDTH-1:0]      s1_a;
  logic [2:0][B_WIDTH-1:0]      s1_b;
  logic [2:0][PW-1:0]           s1_prod;
  logic [2:0][PW-1:0]           s2_prod;
  logic signed [SW-1:0]         s2_sum;
  logic signed [SW-1:0]         s2_shift;
  logic [D_WIDTH-1:0]           s3_data;

  always_comb begin
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    s1_prod = '0;
    a_ext   = '0;
    b_ext   = '0;
    for (int k = 0; k < 3; k++) begin
      a_ext      = PW'($signed(s1_a[k]));
      b_ext      = PW'($signed(s1_b[k]));
      s1_prod[k] = a_ext * b_ext;
    end
  end

  // Floor semantics come from the arithmetic shift; D_WIDTH leaves room for the
  // three-term sum so the truncation below never wraps.
  always_comb begin
    s2_sum   = SW'($signed(s2_prod[0])) + SW'($signed(s2_prod[1])) + SW'($signed(s2_prod[2]));
    s2_shift = s2_sum >>> EXTRA;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= issue;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // NOTE: payload registers and the FIFO storage carry no reset; only the valid
  // bits and pointers need it, and leaving memories unreset keeps them as plain RAM.
  always_ff @(posedge clk_in) begin
    if (issue) begin
      s1_id <= grant_id;
      s1_a  <= req_a_in[grant_id];
      s1_b  <= req_b_in[grant_id];
    end
    s2_id   <= s1_id;
    s2_prod <= s1_prod;
    s3_id   <= s2_id;
    s3_data <= D_WIDTH'(s2_shift);
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  res_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  res_t             head;

  assign push = s3_valid;
  assign pop  = res_valid_out && res_ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= '{id: s3_id, data: s3_data};
  end

  assign head          = fifo_mem[rd_ptr];
  assign res_valid_out = rst_in && (fifo_count != '0);
  assign res_data_out  = res_valid_out ? head.data : '0;
  assign res_id_out    = res_valid_out ? head.id : '0;
  assign busy_out      = rst_in && busy_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_grant_onehot: assert property (@(posedge clk_in) disable iff (!rst_in)
    $onehot0(req_ready_out));
  a_no_push_full: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(push && fifo_count == CNT_W'(FIFO_DEPTH)));
  a_grant_valid: assert property (@(posedge clk_in) disable iff (!rst_in)
    (req_ready_out & ~req_valid_in) == '0);

endmodule

// File: tb/tb_dot_arbiter.sv
// Directed self-checking bench for dot_arbiter: reset, single op, round-robin,
// backpressure, rounding/sign, reset mid-flight and sparse contention.
module tb_dot_arbiter;

  logic                   clk_in;
  logic                   rst_in;
  logic [3:0]             req_valid_in;
  logic [3:0]             req_ready_out;
  logic [3:0][2:0][15:0]  req_a_in;
  logic [3:0][2:0][15:0]  req_b_in;
  logic                   res_valid_out;
  logic                   res_ready_in;
  logic [19:0]            res_data_out;
  logic [1:0]             res_id_out;
  logic                   busy_out;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected results for the shared operand set: A=(1000*(i+1),-500,7), B=(1.0,1.0,1.0).
  int rr_exp [4] = '{507, 1507, 2507, 3507};

  dot_arbiter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_id_out    (res_id_out),
    .busy_out      (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to just after the next rising edge; inputs change here, outputs are sampled #1 later.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst_in       = 1'b0;
    req_valid_in = '0;
    cyc();
    cyc();
    rst_in = 1'b1;
  endtask

  task automatic load_rr_data();
    for (int i = 0; i < 4; i++) begin
      req_a_in[i][0] = 16'(1000 * (i + 1));
      req_a_in[i][1] = 16'hFE0C;   // -500
      req_a_in[i][2] = 16'd7;
      req_b_in[i][0] = 16'd16384;
      req_b_in[i][1] = 16'd16384;
      req_b_in[i][2] = 16'd16384;
    end
  endtask

  task automatic test_reset();
    rst_in       = 1'b0;
    res_ready_in = 1'b1;
    load_rr_data();
    req_valid_in = 4'hF;
    cyc();
    cyc();
    #1;
    tests_run++;
    if (req_ready_out !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 0000", req_ready_out);
    end
    tests_run++;
    if (res_valid_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_res_valid: got %b expected 0", res_valid_out);
    end
    tests_run++;
    if (res_data_out !== 20'd0 || res_id_out !== 2'd0) begin
      tests_failed++; $display("FAIL reset_res_data: got %0h/%0d expected 0/0", res_data_out, res_id_out);
    end
    tests_run++;
    if (busy_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_out);
    end
    cyc();
    rst_in       = 1'b1;
    req_valid_in = '0;
  endtask

  task automatic test_single_op();
    apply_reset();
    res_ready_in   = 1'b1;
    req_a_in[0][0] = 16'd16384;
    req_a_in[0][1] = 16'd16384;
    req_a_in[0][2] = 16'd16384;
    req_b_in[0][0] = 16'd8192;
    req_b_in[0][1] = 16'hE000;   // -8192
    req_b_in[0][2] = 16'd16384;
    req_valid_in   = 4'b0001;
    #1;
    tests_run++;
    if (req_ready_out !== 4'b0001) begin
      tests_failed++; $display("FAIL single_ready: got %b expected 0001", req_ready_out);
    end
    cyc();
    req_valid_in = '0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      tests_run++;
      if (res_valid_out !== (c == 4)) begin
        tests_failed++; $display("FAIL single_valid c=%0d: got %b expected %b", c, res_valid_out, (c == 4));
      end
      if (c == 4) begin
        tests_run++;
        if (res_data_out !== 20'd16384 || res_id_out !== 2'd0) begin
          tests_failed++;
          $display("FAIL single_data: got %0d/id%0d expected 16384/id0", $signed(res_data_out), res_id_out);
        end
      end
      if (c == 1 || c == 5) begin
        tests_run++;
        if (busy_out !== (c == 1)) begin
          tests_failed++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy_out, (c == 1));
        end
      end
      cyc();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    apply_reset();
    load_rr_data();
    res_ready_in = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      req_valid_in = (c < 12) ? 4'hF : 4'h0;
      #1;
      exp_ready = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
      tests_run++;
      if (req_ready_out !== exp_ready) begin
        tests_failed++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready_out, exp_ready);
      end
      tests_run++;
      if (res_valid_out !== (c >= 4 && c < 16)) begin
        tests_failed++; $display("FAIL rr_valid c=%0d: got %b expected %b", c, res_valid_out, (c >= 4 && c < 16));
      end
      if (c >= 4 && c < 16) begin
        exp_id = 2'((c - 4) % 4);
        tests_run++;
        if (res_id_out !== exp_id || res_data_out !== 20'(rr_exp[exp_id])) begin
          tests_failed++;
          $display("FAIL rr_result c=%0d: got %0d/id%0d expected %0d/id%0d",
                   c, $signed(res_data_out), res_id_out, rr_exp[exp_id], exp_id);
        end
      end
      if (c == 16) begin
        tests_run++;
        if (busy_out !== 1'b0) begin
          tests_failed++; $display("FAIL rr_busy_idle: got %b expected 0", busy_out);
        end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    logic       exp_valid;
    apply_reset();
    load_rr_data();
    for (int c = 0; c <= 24; c++) begin
      req_valid_in = (c <= 16) ? 4'hF : 4'h0;
      res_ready_in = (c >= 15);
      #1;
      if (c < 8)        exp_ready = 4'b0001 << (c % 4);
      else if (c == 16) exp_ready = 4'b0001;
      else              exp_ready = 4'b0000;
      tests_run++;
      if (req_ready_out !== exp_ready) begin
        tests_failed++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, req_ready_out, exp_ready);
      end
      exp_valid = (c >= 4 && c <= 23);
      tests_run++;
      if (res_valid_out !== exp_valid) begin
        tests_failed++; $display("FAIL bp_valid c=%0d: got %b expected %b", c, res_valid_out, exp_valid);
      end
      if (exp_valid) begin
        if (c <= 14 || c == 23) exp_id = 2'd0;
        else                    exp_id = 2'((c - 15) % 4);
        tests_run++;
        if (res_id_out !== exp_id || res_data_out !== 20'(rr_exp[exp_id])) begin
          tests_failed++;
          $display("FAIL bp_result c=%0d: got %0d/id%0d expected %0d/id%0d",
                   c, $signed(res_data_out), res_id_out, rr_exp[exp_id], exp_id);
        end
      end
      if (c == 10 || c == 24) begin
        tests_run++;
        if (busy_out !== (c == 10)) begin
          tests_failed++; $display("FAIL bp_busy c=%0d: got %b expected %b", c, busy_out, (c == 10));
        end
      end
      cyc();
    end
  endtask

  task automatic test_rounding();
    apply_reset();
    res_ready_in = 1'b1;
    req_a_in[1]  = {16'd0, 16'd0, 16'd1};
    req_b_in[1]  = {16'd0, 16'd0, 16'hFFFF};   // -1
    req_a_in[3]  = {16'h8000, 16'h8000, 16'h8000};
    req_b_in[3]  = {16'h8000, 16'h8000, 16'h8000};
    for (int c = 0; c <= 6; c++) begin
      req_valid_in = (c == 0) ? 4'b1010 : (c == 1) ? 4'b1000 : 4'b0000;
      #1;
      if (c == 0) begin
        tests_run++;
        if (req_ready_out !== 4'b0010) begin
          tests_failed++; $display("FAIL round_grant0: got %b expected 0010", req_ready_out);
        end
      end
      if (c == 1) begin
        tests_run++;
        if (req_ready_out !== 4'b1000) begin
          tests_failed++; $display("FAIL round_grant1: got %b expected 1000", req_ready_out);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (res_valid_out !== 1'b1 || res_data_out !== 20'hFFFFF || res_id_out !== 2'd1) begin
          tests_failed++;
          $display("FAIL round_floor: got v%b %0d/id%0d expected v1 -1/id1",
                   res_valid_out, $signed(res_data_out), res_id_out);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (res_valid_out !== 1'b1 || res_data_out !== 20'd196608 || res_id_out !== 2'd3) begin
          tests_failed++;
          $display("FAIL round_max: got v%b %0d/id%0d expected v1 196608/id3",
                   res_valid_out, $signed(res_data_out), res_id_out);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (res_valid_out !== 1'b0) begin
          tests_failed++; $display("FAIL round_empty: got %b expected 0", res_valid_out);
        end
      end
      cyc();
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] exp_ready;
    apply_reset();
    load_rr_data();
    res_ready_in = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      rst_in = (c != 4);
      if (c <= 2 || c == 4) req_valid_in = 4'b0111;
      else if (c == 5)      req_valid_in = 4'b0110;
      else                  req_valid_in = 4'b0000;
      #1;
      if (c <= 2)      exp_ready = 4'b0001 << c;
      else if (c == 5) exp_ready = 4'b0010;
      else             exp_ready = 4'b0000;
      tests_run++;
      if (req_ready_out !== exp_ready) begin
        tests_failed++; $display("FAIL mid_ready c=%0d: got %b expected %b", c, req_ready_out, exp_ready);
      end
      tests_run++;
      if (res_valid_out !== (c == 9)) begin
        tests_failed++; $display("FAIL mid_valid c=%0d: got %b expected %b", c, res_valid_out, (c == 9));
      end
      if (c == 4) begin
        tests_run++;
        if (res_data_out !== 20'd0 || res_id_out !== 2'd0) begin
          tests_failed++; $display("FAIL mid_reset_data: got %0h/id%0d expected 0/id0", res_data_out, res_id_out);
        end
      end
      if (c == 5 || c == 10) begin
        tests_run++;
        if (busy_out !== 1'b0) begin
          tests_failed++; $display("FAIL mid_busy c=%0d: got %b expected 0", c, busy_out);
        end
      end
      if (c == 9) begin
        tests_run++;
        if (res_data_out !== 20'd1507 || res_id_out !== 2'd1) begin
          tests_failed++; $display("FAIL mid_result: got %0d/id%0d expected 1507/id1", $signed(res_data_out), res_id_out);
        end
      end
      cyc();
    end
    rst_in = 1'b1;
  endtask

  task automatic test_sparse();
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    apply_reset();
    load_rr_data();
    res_ready_in = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      req_valid_in = (c < 3) ? 4'b1100 : 4'b0000;
      #1;
      exp_ready = (c == 0 || c == 2) ? 4'b0100 : (c == 1) ? 4'b1000 : 4'b0000;
      tests_run++;
      if (req_ready_out !== exp_ready) begin
        tests_failed++; $display("FAIL sparse_ready c=%0d: got %b expected %b", c, req_ready_out, exp_ready);
      end
      tests_run++;
      if (res_valid_out !== (c >= 4 && c <= 6)) begin
        tests_failed++; $display("FAIL sparse_valid c=%0d: got %b expected %b", c, res_valid_out, (c >= 4 && c <= 6));
      end
      if (c >= 4 && c <= 6) begin
        exp_id = (c == 5) ? 2'd3 : 2'd2;
        tests_run++;
        if (res_id_out !== exp_id || res_data_out !== 20'(rr_exp[exp_id])) begin
          tests_failed++;
          $display("FAIL sparse_result c=%0d: got %0d/id%0d expected %0d/id%0d",
                   c, $signed(res_data_out), res_id_out, rr_exp[exp_id], exp_id);
        end
      end
      cyc();
    end
  endtask

  initial begin
    rst_in       = 1'b0;
    req_valid_in = '0;
    res_ready_in = 1'b0;
    req_a_in     = '0;
    req_b_in     = '0;
    cyc();
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_rounding();
    test_reset_midflight();
    test_sparse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
